// File: rtl/game_flow_controller_if.sv
// Pinball game-flow bus: player keys and collision events going into the
// flow controller, plus the strobes and counters it drives to the ball,
// obstacle and display blocks.
//   slave  : seen by game_flow_controller (events in, strobes/counters out)
//   master : seen by the driver of events / consumer of strobes
interface game_flow_controller_if #(
  parameter int SCORE_W = 8,
  parameter int LEVEL_W = 4,
  parameter int LIFE_W  = 4,
  parameter int HITS_W  = 3
);
  logic               start;
  logic               key5IsPressed;
  logic               keyPauseIsPressed;
  logic               collisionBallObstacle;
  logic               collisionBallObstacleGood;
  logic               collisionBallObstacleBad;
  logic               collisionBallBottom;
  logic               pause;
  logic               reset_level;
  logic               reset_level_pulse;
  logic [SCORE_W-1:0] score;
  logic [LEVEL_W-1:0] level;
  logic [LIFE_W-1:0]  life;
  logic [HITS_W-1:0]  level_hits;
  logic               game_over;
  logic               game_won;

  modport slave (
    input  start, key5IsPressed, keyPauseIsPressed, collisionBallObstacle,
           collisionBallObstacleGood, collisionBallObstacleBad, collisionBallBottom,
    output pause, reset_level, reset_level_pulse, score, level, life, level_hits,
           game_over, game_won
  );

  modport master (
    output start, key5IsPressed, keyPauseIsPressed, collisionBallObstacle,
           collisionBallObstacleGood, collisionBallObstacleBad, collisionBallBottom,
    input  pause, reset_level, reset_level_pulse, score, level, life, level_hits,
           game_over, game_won
  );
endinterface

// File: rtl/game_flow_controller.sv
// Game-flow FSM for the pinball top level.
// Sequences idle / serve / play / user-pause / game-over / win and keeps the
// cumulative score, per-level good-hit count, level and lives.
// Ports:
//   clk    : system clock
//   resetN : asynchronous active-low reset
//   bus    : game_flow_controller_if.slave (keys, collisions in; pause,
//            reset_level, reset_level_pulse, score, level, life, level_hits,
//            game_over, game_won out)
module game_flow_controller #(
  parameter int SCORE_W      = 8,
  parameter int LEVEL_W      = 4,
  parameter int LIFE_W       = 4,
  parameter int LIFE_INIT    = 3,
  parameter int LIFE_MAX     = 9,
  parameter int POINTS_GOOD  = 2,
  parameter int PENALTY_BAD  = 1,
  parameter int LEVEL_TARGET = 4,
  parameter int MAX_LEVEL    = 3,
  localparam int HITS_W      = $clog2(LEVEL_TARGET + 1)
) (
  input  logic clk,
  input  logic resetN,
  game_flow_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SERVE, S_PLAY, S_PAUSED, S_OVER, S_WIN
  } state_e;

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LIFE_W-1:0]  life_q, life_d;
  logic [HITS_W-1:0]  hits_q, hits_d;
  logic               key5_q, keyp_q, rl_q;

  logic rise_k5, rise_kp;
  logic hit_good, hit_bad;
  logic pause_c, rl_c, over_c, won_c;

  assign rise_k5  = bus.key5IsPressed & ~key5_q;
  assign rise_kp  = bus.keyPauseIsPressed & ~keyp_q;
  // Good wins when both good and bad are flagged on the same collision.
  assign hit_good = bus.collisionBallObstacle & bus.collisionBallObstacleGood;
  assign hit_bad  = bus.collisionBallObstacle & bus.collisionBallObstacleBad & ~hit_good;

  // Saturating score arithmetic, done one bit wider to catch the overflow.
  localparam logic [SCORE_W:0] SCORE_MAX = {1'b0, {SCORE_W{1'b1}}};
  logic [SCORE_W:0]   sum_good;
  logic [SCORE_W-1:0] score_good, score_bad;
  logic [LIFE_W-1:0]  life_bonus;
  logic               level_done, last_level;

  assign sum_good   = {1'b0, score_q} + (SCORE_W+1)'(POINTS_GOOD);
  assign score_good = (sum_good > SCORE_MAX) ? {SCORE_W{1'b1}} : sum_good[SCORE_W-1:0];
  assign score_bad  = ({1'b0, score_q} < (SCORE_W+1)'(PENALTY_BAD)) ? '0
                    : score_q - SCORE_W'(PENALTY_BAD);
  assign life_bonus = (life_q >= LIFE_W'(LIFE_MAX)) ? LIFE_W'(LIFE_MAX)
                    : life_q + LIFE_W'(1);
  assign level_done = (hits_q == HITS_W'(LEVEL_TARGET - 1));
  assign last_level = (level_q == LEVEL_W'(MAX_LEVEL - 1));

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Counters, key edge detectors and the reset_level history bit
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      score_q <= '0;
      level_q <= '0;
      life_q  <= LIFE_W'(LIFE_INIT);
      hits_q  <= '0;
      key5_q  <= 1'b0;
      keyp_q  <= 1'b0;
      rl_q    <= 1'b0;
    end else begin
      score_q <= score_d;
      level_q <= level_d;
      life_q  <= life_d;
      hits_q  <= hits_d;
      key5_q  <= bus.key5IsPressed;
      keyp_q  <= bus.keyPauseIsPressed;
      rl_q    <= rl_c;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    level_d = level_q;
    life_d  = life_q;
    hits_d  = hits_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_SERVE;
      S_SERVE:  if (rise_k5)   state_d = S_PLAY;
      S_PLAY: begin
        if (bus.collisionBallBottom) begin
          // Ball lost: obstacle hits in this cycle are dropped.
          life_d  = life_q - LIFE_W'(1);
          state_d = (life_q == LIFE_W'(1)) ? S_OVER : S_SERVE;
        end else begin
          if (hit_good) begin
            score_d = score_good;
            if (level_done) begin
              hits_d = '0;
              life_d = life_bonus;
              if (last_level) begin
                state_d = S_WIN;
              end else begin
                level_d = level_q + LEVEL_W'(1);
                state_d = S_SERVE;
              end
            end else begin
              hits_d = hits_q + HITS_W'(1);
            end
          end else if (hit_bad) begin
            score_d = score_bad;
          end
          // A pause press outranks a level-clear transition; the hit itself
          // is still scored.
          if (rise_kp) state_d = S_PAUSED;
        end
      end
      S_PAUSED: if (rise_kp) state_d = S_PLAY;
      S_OVER, S_WIN: begin
        if (rise_k5) begin
          score_d = '0;
          level_d = '0;
          hits_d  = '0;
          life_d  = LIFE_W'(LIFE_INIT);
          state_d = S_SERVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    pause_c = (state_q != S_PLAY);
    rl_c    = (state_q == S_SERVE) || (state_q == S_OVER) || (state_q == S_WIN);
    over_c  = (state_q == S_OVER);
    won_c   = (state_q == S_WIN);
  end

  assign bus.pause             = pause_c;
  assign bus.reset_level       = rl_c;
  assign bus.reset_level_pulse = rl_c & ~rl_q;
  assign bus.game_over         = over_c;
  assign bus.game_won          = won_c;
  assign bus.score             = score_q;
  assign bus.level             = level_q;
  assign bus.life              = life_q;
  assign bus.level_hits        = hits_q;

endmodule

// File: tb/tb_game_flow_controller.sv
module tb_game_flow_controller;
  localparam int SCORE_W = 8, LEVEL_W = 4, LIFE_W = 4;
  localparam int HITS_W  = $clog2(4 + 1);
  localparam int L_INIT = 3, L_MAX = 9, PG = 2, PB = 1, TGT = 4, NLVL = 3;
  localparam int SMAX = (1 << SCORE_W) - 1;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  game_flow_controller_if #(.SCORE_W(SCORE_W), .LEVEL_W(LEVEL_W), .LIFE_W(LIFE_W),
                            .HITS_W(HITS_W)) bus ();

  game_flow_controller dut (.clk(clk), .resetN(resetN), .bus(bus.slave));

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: game phase and counters as plain integers.
  typedef enum {M_IDLE, M_SERVE, M_PLAY, M_PAUSED, M_OVER, M_WIN} mph_e;
  mph_e m_ph;
  int   m_score, m_level, m_life, m_hits;
  bit   m_k5, m_kp, m_rl_prev;

  function automatic bit m_rl(input mph_e p);
    return (p == M_SERVE) || (p == M_OVER) || (p == M_WIN);
  endfunction

  task automatic model_reset();
    m_ph = M_IDLE; m_score = 0; m_level = 0; m_life = L_INIT; m_hits = 0;
    m_k5 = 0; m_kp = 0; m_rl_prev = 0;
  endtask

  task automatic model_step();
    bit rk5, rkp, good, bad;
    mph_e nx;
    rk5  = bus.key5IsPressed && !m_k5;
    rkp  = bus.keyPauseIsPressed && !m_kp;
    good = bus.collisionBallObstacle && bus.collisionBallObstacleGood;
    bad  = bus.collisionBallObstacle && bus.collisionBallObstacleBad && !good;
    m_rl_prev = m_rl(m_ph);
    nx = m_ph;
    case (m_ph)
      M_IDLE:   if (bus.start) nx = M_SERVE;
      M_SERVE:  if (rk5) nx = M_PLAY;
      M_PLAY:
        if (bus.collisionBallBottom) begin
          m_life--;
          nx = (m_life == 0) ? M_OVER : M_SERVE;
        end else begin
          if (good) begin
            m_score = (m_score + PG > SMAX) ? SMAX : m_score + PG;
            if (m_hits + 1 == TGT) begin
              m_hits = 0;
              m_life = (m_life + 1 > L_MAX) ? L_MAX : m_life + 1;
              if (m_level == NLVL - 1) nx = M_WIN;
              else begin m_level++; nx = M_SERVE; end
            end else m_hits++;
          end else if (bad) begin
            m_score = (m_score < PB) ? 0 : m_score - PB;
          end
          if (rkp) nx = M_PAUSED;
        end
      M_PAUSED: if (rkp) nx = M_PLAY;
      default:
        if (rk5) begin
          m_score = 0; m_level = 0; m_hits = 0; m_life = L_INIT; nx = M_SERVE;
        end
    endcase
    m_ph = nx;
    m_k5 = bus.key5IsPressed;
    m_kp = bus.keyPauseIsPressed;
  endtask

  task automatic check_all();
    chk("pause",       bus.pause,             (m_ph != M_PLAY));
    chk("reset_level", bus.reset_level,       m_rl(m_ph));
    chk("rl_pulse",    bus.reset_level_pulse, m_rl(m_ph) && !m_rl_prev);
    chk("game_over",   bus.game_over,         (m_ph == M_OVER));
    chk("game_won",    bus.game_won,          (m_ph == M_WIN));
    chk("score",       bus.score,             m_score);
    chk("level",       bus.level,             m_level);
    chk("life",        bus.life,              m_life);
    chk("level_hits",  bus.level_hits,        m_hits);
  endtask

  // One clock: drive inputs at the falling edge, step model at the rising
  // edge, compare at the next falling edge.
  task automatic cyc(input bit st, k5, kp, co, gd, bd, bt);
    bus.start = st; bus.key5IsPressed = k5; bus.keyPauseIsPressed = kp;
    bus.collisionBallObstacle = co; bus.collisionBallObstacleGood = gd;
    bus.collisionBallObstacleBad = bd; bus.collisionBallBottom = bt;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic launch();
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset asserted between edges; outputs must change before any clock edge.
  task automatic async_reset();
    #3 resetN = 1'b0;
    #1 model_reset();
    chk("arst_pause", bus.pause, 1);
    chk("arst_rl",    bus.reset_level, 0);
    chk("arst_score", bus.score, 0);
    chk("arst_life",  bus.life, L_INIT);
    check_all();
    @(negedge clk);
    resetN = 1'b1;
    bus.key5IsPressed = 0; bus.keyPauseIsPressed = 0;
  endtask

  initial begin
    resetN = 1'b0;
    bus.start = 0; bus.key5IsPressed = 0; bus.keyPauseIsPressed = 0;
    bus.collisionBallObstacle = 0; bus.collisionBallObstacleGood = 0;
    bus.collisionBallObstacleBad = 0; bus.collisionBallBottom = 0;
    model_reset();
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    check_all();

    // Start, serve, launch
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("serve_rl", bus.reset_level, 1);
    chk("serve_pulse", bus.reset_level_pulse, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("serve_pulse_once", bus.reset_level_pulse, 0);
    launch();
    chk("play_pause", bus.pause, 0);
    chk("play_life", bus.life, 3);

    // Level 0 cleared with four good hits
    repeat (3) cyc(0, 0, 0, 1, 1, 0, 0);
    chk("p2_score", bus.score, 6);
    chk("p2_hits", bus.level_hits, 3);
    cyc(0, 0, 0, 1, 1, 0, 0);
    chk("p2_level", bus.level, 1);
    chk("p2_life", bus.life, 4);
    chk("p2_pulse", bus.reset_level_pulse, 1);
    launch();

    // Lose balls down to the last life, then bottom + good together
    while (m_life > 1) begin
      cyc(0, 0, 0, 0, 0, 0, 1);
      launch();
    end
    cyc(0, 0, 0, 1, 1, 0, 1);
    chk("p4_life", bus.life, 0);
    chk("p4_score", bus.score, 8);
    chk("p4_over", bus.game_over, 1);

    // Restart with key5 held across serve entry
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("p4_restart_life", bus.life, 3);
    chk("p4_restart_score", bus.score, 0);
    chk("p4_restart_pulse", bus.reset_level_pulse, 0);
    repeat (2) cyc(0, 1, 0, 0, 0, 0, 0);
    chk("p5_held_no_launch", bus.pause, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    launch();
    chk("p5_launched", bus.pause, 0);

    // Score arithmetic
    cyc(0, 0, 0, 1, 0, 1, 0);
    chk("p3_bad_floor", bus.score, 0);
    cyc(0, 0, 0, 1, 1, 1, 0);
    chk("p3_good_and_bad", bus.score, 2);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("p3_unqualified", bus.score, 2);

    // User pause ignores hits
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("p5_paused", bus.pause, 1);
    cyc(0, 0, 1, 1, 1, 0, 1);
    chk("p5_pause_ignore", bus.score, 2);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("p5_unpaused", bus.pause, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Play through to the win
    for (int i = 0; i < 40 && m_ph != M_WIN; i++) begin
      cyc(0, 0, 0, 1, 1, 0, 0);
      if (m_ph == M_SERVE) launch();
    end
    chk("p6_won", bus.game_won, 1);
    chk("p6_level", bus.level, 2);
    chk("p6_life", bus.life, 6);

    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    launch();
    cyc(0, 0, 0, 1, 1, 0, 0);
    async_reset();

    // Randomised play against the model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 499) == 0) async_reset();
      else cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 15) == 0), ($urandom_range(0, 1) == 1),
               ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 39) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
